// File: rtl/rom_download_sdram_pkg.sv
// Shared types for the ROM download feeder: FSM states and port1 byte-enable codes.
package rom_download_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ISSUE,
    FLUSH
  } state_e;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

endpackage

// File: rtl/rom_download_sdram.sv
// Packs the HPS ioctl byte stream into 16-bit words and writes them to SDRAM
// port1 with a toggle req/ack handshake, stalling the HPS while a write is in flight.
module rom_download_sdram
  import rom_download_sdram_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [22:0] BASE_WADDR = 23'h000000,
  parameter logic [24:0] MAX_BYTES  = 25'h100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        rom_ready
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [22:0] a_q, a_d;
  logic [1:0]  ds_q, ds_d;
  logic [15:0] d_q, d_d;
  logic        wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        active_q;
  logic        first_q;
  logic [7:0]  hold_byte_q, hold_byte_d;
  logic [24:0] hold_addr_q, hold_addr_d;
  logic [7:0]  replay_byte_q, replay_byte_d;
  logic [24:0] replay_addr_q, replay_addr_d;

  logic        active, wr_ok, req_cur, acked;
  logic        byte_go, issue;
  logic [7:0]  byte_val;
  logic [24:0] byte_addr;
  logic [22:0] iss_waddr;
  logic [1:0]  iss_ds;
  logic [15:0] iss_data;

  assign active  = ioctl_download && (ioctl_index == ROM_INDEX);
  assign wr_ok   = active && ioctl_wr && !wait_q && (ioctl_addr < MAX_BYTES);
  // Right after reset the controller may still hold a stale ack; adopt it as our req.
  assign req_cur = first_q ? port1_ack : req_q;
  assign acked   = (port1_ack == req_cur);

  always_comb begin
    state_d       = state_q;
    req_d         = req_cur;
    we_d          = we_q;
    a_d           = a_q;
    ds_d          = ds_q;
    d_d           = d_q;
    hold_byte_d   = hold_byte_q;
    hold_addr_d   = hold_addr_q;
    replay_byte_d = replay_byte_q;
    replay_addr_d = replay_addr_q;
    ready_d       = ready_q;
    byte_go       = 1'b0;
    byte_val      = ioctl_dout;
    byte_addr     = ioctl_addr;
    issue         = 1'b0;
    iss_waddr     = hold_addr_q[23:1];
    iss_ds        = DS_LO;
    iss_data      = {8'h00, hold_byte_q};

    case (state_q)
      IDLE: byte_go = wr_ok;
      HOLD: begin
        if (wr_ok && (ioctl_addr == hold_addr_q + 25'd1)) begin
          issue    = 1'b1;
          iss_ds   = DS_BOTH;
          iss_data = {ioctl_dout, hold_byte_q};
          state_d  = ISSUE;
        end else if (wr_ok) begin
          issue         = 1'b1;
          replay_byte_d = ioctl_dout;
          replay_addr_d = ioctl_addr;
          state_d       = FLUSH;
        end else if (!active) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: if (acked) state_d = IDLE;
      FLUSH: begin
        if (acked) begin
          byte_go   = 1'b1;
          byte_val  = replay_byte_q;
          byte_addr = replay_addr_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte seen from an empty latch: even bytes wait for a partner, odd bytes go out alone.
    if (byte_go) begin
      if (!byte_addr[0]) begin
        hold_byte_d = byte_val;
        hold_addr_d = byte_addr;
        state_d     = HOLD;
      end else begin
        issue     = 1'b1;
        iss_waddr = byte_addr[23:1];
        iss_ds    = DS_HI;
        iss_data  = {byte_val, 8'h00};
        state_d   = ISSUE;
      end
    end

    if (issue) begin
      req_d = ~req_cur;
      we_d  = 1'b1;
      a_d   = BASE_WADDR + iss_waddr;
      ds_d  = iss_ds;
      d_d   = iss_data;
    end

    wait_d = (state_d == ISSUE) || (state_d == FLUSH);

    if (active && !active_q) begin
      ready_d = 1'b0;
    end else if (!active && (state_q == IDLE) && acked) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      a_q           <= '0;
      ds_q          <= 2'b00;
      d_q           <= '0;
      wait_q        <= 1'b0;
      ready_q       <= 1'b0;
      active_q      <= 1'b0;
      first_q       <= 1'b1;
      hold_byte_q   <= '0;
      hold_addr_q   <= '0;
      replay_byte_q <= '0;
      replay_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      a_q           <= a_d;
      ds_q          <= ds_d;
      d_q           <= d_d;
      wait_q        <= wait_d;
      ready_q       <= ready_d;
      active_q      <= active;
      first_q       <= 1'b0;
      hold_byte_q   <= hold_byte_d;
      hold_addr_q   <= hold_addr_d;
      replay_byte_q <= replay_byte_d;
      replay_addr_q <= replay_addr_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign port1_req  = req_q;
  assign port1_we   = we_q;
  assign port1_a    = a_q;
  assign port1_ds   = ds_q;
  assign port1_d    = d_q;
  assign rom_ready  = ready_q;

endmodule

// File: tb/tb_rom_download_sdram.sv
// Scoreboard bench for rom_download_sdram: directed byte streams, a delayed-ack
// SDRAM responder and a monitor that checks every port1 request as it appears.
module tb_rom_download_sdram;

  localparam logic [22:0] BASE = 23'h000100;
  localparam logic [24:0] MAXB = 25'h000040;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        port1_req;
  logic        port1_ack = 1'b0;
  logic        port1_we;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        rom_ready;

  int   total = 0;
  int   bad = 0;
  int   toggles = 0;
  int   ack_delay = 5;
  logic resp_en = 1'b1;
  logic mon_resync = 1'b1;
  wr_t  sb_q[$];

  rom_download_sdram #(
    .ROM_INDEX (8'd0),
    .BASE_WADDR(BASE),
    .MAX_BYTES (MAXB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .port1_req     (port1_req),
    .port1_ack     (port1_ack),
    .port1_we      (port1_we),
    .port1_a       (port1_a),
    .port1_ds      (port1_ds),
    .port1_d       (port1_d),
    .rom_ready     (rom_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectWrite(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.ds = ds;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput(name, {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!rom_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, rom_ready}, 32'd1);
  endtask

  // Called at a negedge; the strobe is sampled by the following posedge.
  task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
    waitIdle("pre_wr_timeout");
    checkOutput("wr_during_wait", {31'd0, ioctl_wait}, 32'd0);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  // SDRAM controller stand-in: completes a request ack_delay negedges after seeing it.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_en && reset_n && (port1_req !== port1_ack)) begin
        if (cnt >= ack_delay - 1) begin
          port1_ack = port1_req;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    logic prev = 1'b0;
    wr_t  e;
    forever begin
      @(negedge clk);
      if (!reset_n || mon_resync) begin
        prev = port1_req;
      end else if (port1_req !== prev) begin
        prev = port1_req;
        toggles++;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_write", {9'd0, port1_a}, 32'hFFFFFFFF);
        end else begin
          e = sb_q.pop_front();
          checkOutput("wr_a", {9'd0, port1_a}, {9'd0, e.a});
          checkOutput("wr_ds", {30'd0, port1_ds}, {30'd0, e.ds});
          checkOutput("wr_d", {16'd0, port1_d}, {16'd0, e.d});
          checkOutput("wr_we", {31'd0, port1_we}, 32'd1);
          checkOutput("wr_wait", {31'd0, ioctl_wait}, 32'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetValues();
    checkOutput("rst_req", {31'd0, port1_req}, 32'd0);
    checkOutput("rst_we", {31'd0, port1_we}, 32'd0);
    checkOutput("rst_a", {9'd0, port1_a}, 32'd0);
    checkOutput("rst_ds", {30'd0, port1_ds}, 32'd0);
    checkOutput("rst_d", {16'd0, port1_d}, 32'd0);
    checkOutput("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    checkOutput("rst_ready", {31'd0, rom_ready}, 32'd0);
  endtask

  initial begin
    int tog0;
    int n;

    repeat (3) @(negedge clk);
    checkResetValues();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_resync = 1'b0;
    checkOutput("idle_ready", {31'd0, rom_ready}, 32'd1);

    // Test 1: one full word, ack after 5 cycles
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    @(negedge clk);
    checkOutput("t1_ready_clr", {31'd0, rom_ready}, 32'd0);
    tog0 = toggles;
    expectWrite(BASE, 2'b11, 16'h2211);
    applyStimulus(25'd0, 8'h11);
    applyStimulus(25'd1, 8'h22);
    n = 0;
    while (ioctl_wait && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t1_wait_cycles", n, 32'd5);
    @(negedge clk);
    checkOutput("t1_toggles", toggles - tog0, 32'd1);

    // Test 2: odd byte from empty latch
    ack_delay = 2;
    expectWrite(BASE + 23'd2, 2'b10, 16'h3300);
    applyStimulus(25'd5, 8'h33);

    // Test 3: non-adjacent pair flushes the even byte, new byte is replayed into the latch
    expectWrite(BASE + 23'd4, 2'b01, 16'h0044);
    applyStimulus(25'd8, 8'h44);
    applyStimulus(25'd12, 8'h55);
    expectWrite(BASE + 23'd6, 2'b11, 16'h6655);
    applyStimulus(25'd13, 8'h66);
    waitIdle("t3_idle");

    // Test 4: odd-length image, trailing byte issued when the download ends
    expectWrite(BASE, 2'b11, 16'hBBAA);
    expectWrite(BASE + 23'd1, 2'b01, 16'h00CC);
    applyStimulus(25'd0, 8'hAA);
    applyStimulus(25'd1, 8'hBB);
    applyStimulus(25'd2, 8'hCC);
    waitIdle("t4_idle");
    ioctl_download = 1'b0;
    @(negedge clk);
    checkOutput("t4_flush_wait", {31'd0, ioctl_wait}, 32'd1);
    checkOutput("t4_ready_low", {31'd0, rom_ready}, 32'd0);
    waitReady("t4_ready");
    checkOutput("t4_sb_empty", sb_q.size(), 32'd0);

    // Test 5: foreign index and out-of-range bytes are ignored
    tog0 = toggles;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(25'(i), 8'hF0 + 8'(i));
    repeat (3) @(negedge clk);
    checkOutput("t5_idx_toggles", toggles - tog0, 32'd0);
    checkOutput("t5_idx_ready", {31'd0, rom_ready}, 32'd1);
    ioctl_index = 8'd0;
    applyStimulus(MAXB, 8'hEE);
    applyStimulus(25'h1000002, 8'hEF);
    repeat (3) @(negedge clk);
    checkOutput("t5_drop_toggles", toggles - tog0, 32'd0);
    checkOutput("t5_drop_wait", {31'd0, ioctl_wait}, 32'd0);
    expectWrite(BASE + 23'd1, 2'b10, 16'h7700);
    applyStimulus(25'd3, 8'h77);
    expectWrite(BASE + 23'h1F, 2'b10, 16'h8800);
    applyStimulus(MAXB - 25'd1, 8'h88);
    waitIdle("t5_idle");

    // Test 6: reset while a request is still waiting for its ack
    expectWrite(BASE + 23'd3, 2'b10, 16'h5A00);
    applyStimulus(25'd7, 8'h5A);
    waitIdle("t6_idle");
    @(negedge clk);
    resp_en = 1'b0;
    expectWrite(BASE + 23'd4, 2'b10, 16'h6B00);
    applyStimulus(25'd9, 8'h6B);
    repeat (2) @(negedge clk);
    checkOutput("t6_pending_wait", {31'd0, ioctl_wait}, 32'd1);
    mon_resync = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t6_req_align", {31'd0, port1_req}, 32'd1);
    checkOutput("t6_wait_after", {31'd0, ioctl_wait}, 32'd0);
    mon_resync = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    expectWrite(BASE, 2'b11, 16'h3412);
    applyStimulus(25'd0, 8'h12);
    applyStimulus(25'd1, 8'h34);
    waitIdle("t6_idle2");
    ioctl_download = 1'b0;
    waitReady("t6_ready");
    checkOutput("final_sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
